// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop; one bit per CLK.
// Define UART_TX_BACK_TO_BACK_EN to let a new frame be accepted in STOP with no idle gap.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic [1:0]            mux_sel,
  output logic                  Busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic                  w_lastBit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  logic                  r_parEn;
  logic                  r_parTyp;
  logic                  r_dataXor;

  assign w_lastBit = (r_cnt == CW'(DATA_WIDTH - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    mux_sel  = 2'b00;
    Busy     = 1'b0;
    case (r_state)
      IDLE: begin
        if (Data_Valid) begin
          w_accept = 1'b1;
          w_next   = START;
        end
      end
      START: begin
        mux_sel = 2'b01;
        Busy    = 1'b1;
        w_next  = DATA;
      end
      DATA: begin
        mux_sel = 2'b10;
        Busy    = 1'b1;
        if (w_lastBit) w_next = r_parEn ? PARITY : STOP;
      end
      PARITY: begin
        mux_sel = 2'b11;
        Busy    = 1'b1;
        w_next  = STOP;
      end
      STOP: begin
        Busy   = 1'b1;
        w_next = IDLE;
`ifdef UART_TX_BACK_TO_BACK_EN
        if (Data_Valid) begin
          w_accept = 1'b1;
          w_next   = START;
        end
`endif
      end
      default: w_next = IDLE;
    endcase
  end

  // Parity is kept as data XOR plus latched type so the latched type drives par_bit directly
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_parEn   <= 1'b0;
      r_parTyp  <= 1'b0;
      r_dataXor <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= P_DATA;
      r_cnt     <= '0;
      r_parEn   <= PAR_EN;
      r_parTyp  <= PAR_TYP;
      r_dataXor <= ^P_DATA;
    end else if (r_state == DATA) begin
      r_shift <= r_shift >> 1;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign ser_data = r_shift[0];
  assign par_bit  = r_dataXor ^ r_parTyp;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: hand vectors, corner sequences and random frames
// compared against a frame-level reference model of the serial line.
module tb_uart_tx_ctrl;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] P_DATA = '0;
  logic         Data_Valid = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic         ser_data;
  logic         par_bit;
  logic [1:0]   mux_sel;
  logic         Busy;

  int checks = 0;
  int errors = 0;

  logic [1:0] obsSel[$];
  logic       obsLine[$];

  typedef struct {
    logic [7:0]  d;
    logic        pen;
    logic        ptyp;
    int          len;
    logic        par;
    logic [63:0] line;
  } vec_t;

  vec_t vecs[7];

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data),
    .par_bit(par_bit), .mux_sel(mux_sel), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // TX output mux as wired downstream: stop/idle high, start low
  function automatic logic lineOf(logic [1:0] s, logic d, logic p);
    case (s)
      2'b01:   return 1'b0;
      2'b10:   return d;
      2'b11:   return p;
      default: return 1'b1;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] d, input logic pen, input logic ptyp);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
  endtask

  // Called at the START sample; records the line until Busy drops
  task automatic collectFrame(input bit noise, input bit hold);
    obsSel.delete();
    obsLine.delete();
    for (int c = 0; c < 40; c++) begin
      if (!Busy) begin
        Data_Valid = hold;
        return;
      end
      obsSel.push_back(mux_sel);
      obsLine.push_back(lineOf(mux_sel, ser_data, par_bit));
      if (noise) begin
        P_DATA  = W'($urandom);
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
`ifndef UART_TX_BACK_TO_BACK_EN
        Data_Valid = 1'($urandom_range(0, 1));
`endif
      end
      tick();
    end
    Data_Valid = 1'b0;
    checkOutput("frameTimeout", 64'(Busy), 64'd0);
  endtask

  function automatic logic [63:0] packLine();
    logic [63:0] v = '0;
    for (int k = 0; k < obsLine.size() && k < 64; k++) v[k] = obsLine[k];
    return v;
  endfunction

  // Reference: frame = start(0), data LSB first, optional parity, stop(1)
  task automatic compareFrame(input string name, input logic [W-1:0] d, input logic pen, input logic ptyp);
    int          n;
    logic [63:0] expLine;
    logic [63:0] expSel;
    logic [63:0] gotSel;
    logic        p;
    p       = (^d) ^ ptyp;
    n       = W + 2 + int'(pen);
    expLine = '0;
    expSel  = '0;
    gotSel  = '0;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        expSel[2*k +: 2] = 2'b01;
        expLine[k]       = 1'b0;
      end else if (k <= W) begin
        expSel[2*k +: 2] = 2'b10;
        expLine[k]       = d[k-1];
      end else if (pen && k == W + 1) begin
        expSel[2*k +: 2] = 2'b11;
        expLine[k]       = p;
      end else begin
        expSel[2*k +: 2] = 2'b00;
        expLine[k]       = 1'b1;
      end
    end
    for (int k = 0; k < obsSel.size() && k < 32; k++) gotSel[2*k +: 2] = obsSel[k];
    checkOutput({name, ".len"}, 64'(obsSel.size()), 64'(n));
    checkOutput({name, ".line"}, packLine(), expLine);
    checkOutput({name, ".sel"}, gotSel, expSel);
    checkOutput({name, ".par"}, 64'(par_bit), 64'(p));
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 11, 1'b0, 64'h54A};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 11, 1'b1, 64'h74A};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, 10, 1'b0, 64'h34A};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 11, 1'b0, 64'h5FE};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 11, 1'b1, 64'h602};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 10, 1'b1, 64'h200};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 11, 1'b0, 64'h500};

    // Reset state while held in reset
    #3;
    checkOutput("rst.sel", 64'(mux_sel), 64'd0);
    checkOutput("rst.busy", 64'(Busy), 64'd0);
    checkOutput("rst.ser", 64'(ser_data), 64'd0);
    checkOutput("rst.par", 64'(par_bit), 64'd0);
    #9 RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst.idleLine", 64'(lineOf(mux_sel, ser_data, par_bit)), 64'd1);
      checkOutput("rst.idleBusy", 64'(Busy), 64'd0);
    end

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].d, vecs[i].pen, vecs[i].ptyp);
      collectFrame(1'b0, 1'b0);
      checkOutput($sformatf("vec%0d.len", i), 64'(obsSel.size()), 64'(vecs[i].len));
      checkOutput($sformatf("vec%0d.line", i), packLine(), vecs[i].line);
      checkOutput($sformatf("vec%0d.parConst", i), 64'(par_bit), 64'(vecs[i].par));
      compareFrame($sformatf("vec%0d", i), vecs[i].d, vecs[i].pen, vecs[i].ptyp);
      tick();
    end

`ifndef UART_TX_BACK_TO_BACK_EN
    // Valid held through a frame with data/config changing underneath it
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    tick();
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b1;
    collectFrame(1'b0, 1'b1);
    compareFrame("busy.a5", 8'hA5, 1'b1, 1'b0);
    checkOutput("busy.idleGapBusy", 64'(Busy), 64'd0);
    checkOutput("busy.idleGapSel", 64'(mux_sel), 64'd0);
    tick();
    Data_Valid = 1'b0;
    checkOutput("busy.3cStart", 64'(mux_sel), 64'd1);
    collectFrame(1'b0, 1'b0);
    compareFrame("busy.3c", 8'h3C, 1'b0, 1'b1);
`else
    // New request during STOP chains straight into START
    applyStimulus(8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("b2b.busyHeld", 64'(Busy), 64'd1);
    end
    checkOutput("b2b.stopSel", 64'(mux_sel), 64'd0);
    P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    checkOutput("b2b.startSel", 64'(mux_sel), 64'd1);
    checkOutput("b2b.busy", 64'(Busy), 64'd1);
    checkOutput("b2b.par", 64'(par_bit), 64'd0);
    collectFrame(1'b0, 1'b0);
    compareFrame("b2b.ff", 8'hFF, 1'b1, 1'b0);
`endif
    tick();

    // Reset in the middle of the data phase
    applyStimulus(8'hA5, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("midrst.preSel", 64'(mux_sel), 64'd2);
    checkOutput("midrst.preSer", 64'(ser_data), 64'd0);
    RST = 1'b0;
    #1;
    checkOutput("midrst.sel", 64'(mux_sel), 64'd0);
    checkOutput("midrst.busy", 64'(Busy), 64'd0);
    checkOutput("midrst.ser", 64'(ser_data), 64'd0);
    checkOutput("midrst.par", 64'(par_bit), 64'd0);
    tick();
    tick();
    #2 RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("midrst.idleLine", 64'(lineOf(mux_sel, ser_data, par_bit)), 64'd1);
      checkOutput("midrst.idleBusy", 64'(Busy), 64'd0);
    end

    // Random frames with random gaps and input noise during transmission
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] d;
      logic         pen;
      logic         ptyp;
      int           gap;
      d    = W'($urandom);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      gap  = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick();
      checkOutput("rand.idleBusy", 64'(Busy), 64'd0);
      applyStimulus(d, pen, ptyp);
      collectFrame(1'b1, 1'b0);
      compareFrame($sformatf("rand%0d", i), d, pen, ptyp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmitter.
- Accepts a parallel byte with a valid strobe and latches it, together with the parity configuration.
- Shifts the data out LSB first and computes the parity bit.
- Drives the 2-bit select of the TX output mux through the start, data, parity and stop phases.
- One serial bit per CLK cycle: CLK is the baud-rate clock.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 5..9).

Ports:
- CLK  input  1  baud-rate clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- P_DATA  input  DATA_WIDTH  parallel data to transmit.
- Data_Valid  input  1  request strobe; sampled only when a frame can be accepted.
- PAR_EN  input  1  1 = insert parity bit; latched at accept.
- PAR_TYP  input  1  0 = even, 1 = odd; latched at accept.
- ser_data  output  1  current data bit, to the mux data input.
- par_bit  output  1  computed parity bit, to the mux parity input.
- mux_sel  output  2  00 = stop/idle (line high), 01 = start, 10 = data, 11 = parity.
- Busy  output  1  high while a frame is in progress.

Behaviour:
- Clock and reset: one clock (CLK); reset (RST) is asynchronous, active-low.
- Reset values: state = IDLE, mux_sel = 00, Busy = 0, ser_data = 0, par_bit = 0, bit counter = 0, data/parity-config registers = 0.
- Reset asserted mid-frame: the frame aborts immediately and the line returns to idle-high through mux_sel = 00. No partial frame resumes after reset release.
- States: IDLE, START, DATA, PARITY, STOP.
- mux_sel and Busy are Moore decodes of the state register. There is no combinational path from any input to any output.
  - IDLE: sel 00, Busy 0.
  - START: sel 01, Busy 1.
  - DATA: sel 10, Busy 1.
  - PARITY: sel 11, Busy 1.
  - STOP: sel 00, Busy 1.
- IDLE: if Data_Valid = 1 at a rising edge, the controller on that same edge:
  - loads the shift register with P_DATA;
  - latches PAR_EN and PAR_TYP;
  - computes par_bit (even: XOR-reduce of data; odd: its inverse);
  - clears the counter;
  - moves to START.
  Otherwise it stays in IDLE.
- START: exactly one cycle, then DATA.
- DATA: DATA_WIDTH cycles.
  - ser_data = shift register bit 0.
  - The register shifts right each cycle and the counter increments.
  - On the cycle where counter = DATA_WIDTH-1, next state is PARITY if latched PAR_EN = 1, else STOP.
- PARITY: one cycle, then STOP.
- STOP: one cycle, then IDLE (see Optional Feature).
- Frame length: DATA_WIDTH+3 cycles with parity, DATA_WIDTH+2 without.
- Data_Valid while Busy = 1 is ignored, and P_DATA changes during a frame have no effect.
- Changes to PAR_EN/PAR_TYP mid-frame have no effect; par_bit holds its latched value until the next accept.
- The counter is wide enough for DATA_WIDTH and never wraps within a frame.

Optional Feature:
- Macro: UART_TX_BACK_TO_BACK_EN.
- Defined: in STOP, Data_Valid = 1 performs the accept actions and moves directly to START. Busy stays high, giving zero idle cycles between frames.
- Undefined: STOP always goes to IDLE, so there is at least one idle-high cycle between frames, and Data_Valid in STOP is ignored.

Test Plan:
- Reset check: assert RST low mid-operation -> mux_sel = 00, Busy = 0, ser_data = 0, par_bit = 0 immediately; stays in IDLE with Data_Valid = 0 after release.
- Even-parity frame: P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 0, one-cycle Data_Valid, mux model tied stop = 1, start = 0 ->
  - line sequence 0,1,0,1,0,0,1,0,1,0,1;
  - mux_sel sequence 01, 10×8, 11, 00;
  - Busy high for exactly 11 cycles.
- Odd parity: 0xA5 with PAR_TYP = 1 -> par_bit = 1. No parity: PAR_EN = 0 -> 10-cycle frame 0,1,0,1,0,0,1,0,1,1 and no 11 select.
- Busy protection: Data_Valid with 0x3C held high through a 0xA5 frame, P_DATA changed mid-frame ->
  - 0xA5 is transmitted intact;
  - without the macro, 0x3C starts only after one IDLE cycle.
- Back-to-back (UART_TX_BACK_TO_BACK_EN defined): Data_Valid high in STOP with P_DATA = 0xFF -> START follows STOP directly, Busy never drops, even par_bit = 0.
- Reset mid-DATA: RST low at data bit 3 of 0xA5 -> mux_sel = 00 at once; after release with Data_Valid low the line stays high.
